// File: rtl/tracker.sv
// Colour-blob tracker: accumulates coordinates of in-window hue pixels per frame
// and divides at the start of vertical blanking to produce the centre of mass.
//
// state  | meaning
// S_IDLE | no division in flight
// S_DIV  | shifting one quotient bit per clock into both dividers
// S_DONE | quotients final; publish x_com/y_com and pulse data_ready
module tracker #(
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768,
    parameter int ACC_W    = 30,
    parameter int CNT_W    = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [23:0] hsv,
    input  logic [7:0]  low,
    input  logic [7:0]  high,
    output logic [10:0] x_com,
    output logic [9:0]  y_com,
    output logic        data_ready
);

    localparam int IT_W = $clog2(ACC_W + 1);
    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;
    state_t state, state_nxt;

    logic [ACC_W-1:0] sum_x, sum_y;
    logic [CNT_W-1:0] count;
    logic             armed;

    logic [ACC_W-1:0] qx, qy;
    logic [CNT_W-1:0] rx, ry, dvs;
    logic [IT_W-1:0]  iter;

    logic [7:0] hue;
    logic       match, trigger, start;
    logic       unused_sv;

    assign hue       = hsv[23:16];
    assign unused_sv = ^hsv[15:0];

    always_comb begin
        match   = (hcount < H_LIM) && (vcount < V_LIM) && (hue >= low) && (hue <= high);
        trigger = (vcount >= V_LIM) && armed;
        start   = trigger && (count != '0);
    end

    // Pixel on the trigger edge is blanking, so clearing and accumulating never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
            armed <= 1'b1;
        end else if (trigger) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
            armed <= 1'b0;
        end else begin
            if (match) begin
                sum_x <= sum_x + ACC_W'(hcount);
                sum_y <= sum_y + ACC_W'(vcount);
                count <= count + CNT_W'(1);
            end
            if (vcount < V_LIM)
                armed <= 1'b1;
        end
    end

    // One restoring step per divider; quotient bits shift into the dividend register.
    logic [CNT_W:0]   tx, ty, dx, dy;
    logic             gx, gy;
    logic [CNT_W-1:0] rx_nxt, ry_nxt;

    always_comb begin
        tx     = {rx, qx[ACC_W-1]};
        ty     = {ry, qy[ACC_W-1]};
        dx     = tx - {1'b0, dvs};
        dy     = ty - {1'b0, dvs};
        gx     = tx >= {1'b0, dvs};
        gy     = ty >= {1'b0, dvs};
        rx_nxt = gx ? dx[CNT_W-1:0] : tx[CNT_W-1:0];
        ry_nxt = gy ? dy[CNT_W-1:0] : ty[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_DIV;
        end else begin
            case (state)
                S_IDLE: state_nxt = S_IDLE;
                S_DIV:  if (iter == IT_W'(1)) state_nxt = S_DONE;
                S_DONE: state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qx         <= '0;
            qy         <= '0;
            rx         <= '0;
            ry         <= '0;
            dvs        <= '0;
            iter       <= '0;
            x_com      <= '0;
            y_com      <= '0;
            data_ready <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            if (start) begin
                qx   <= sum_x;
                qy   <= sum_y;
                rx   <= '0;
                ry   <= '0;
                dvs  <= count;
                iter <= IT_W'(ACC_W);
            end else if (state == S_DIV) begin
                qx   <= {qx[ACC_W-2:0], gx};
                qy   <= {qy[ACC_W-2:0], gy};
                rx   <= rx_nxt;
                ry   <= ry_nxt;
                iter <= iter - IT_W'(1);
            end else if (state == S_DONE) begin
                x_com      <= qx[10:0];
                y_com      <= qy[9:0];
                data_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tracker.sv
// Self-checking bench for tracker: a behavioural frame model pushes expected
// centroids and pulse times to a scoreboard that is popped on each data_ready.
module tb_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [23:0] hsv;
    logic [7:0]  low, high;
    logic [10:0] x_com;
    logic [9:0]  y_com;
    logic        data_ready;

    tracker dut (
        .clk(clk), .reset(rst_n), .hcount(hcount), .vcount(vcount), .hsv(hsv),
        .low(low), .high(high), .x_com(x_com), .y_com(y_com), .data_ready(data_ready)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; int cyc;} exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pulses = 0;

    longint mx = 0, my = 0, mc = 0;
    bit m_armed = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Apply one pixel, update the model for the coming edge, then step past it.
    task automatic px(input int h, input int v, input logic [7:0] hue);
        exp_t e;
        hcount = 11'(h);
        vcount = 10'(v);
        hsv    = {hue, 8'h55, 8'hAA};
        if (rst_n) begin
            if (v >= 768) begin
                if (m_armed) begin
                    if (mc != 0) begin
                        e.x   = int'(mx / mc);
                        e.y   = int'(my / mc);
                        e.cyc = cyc + 1 + 31;
                        sb.push_back(e);
                    end
                    mx = 0; my = 0; mc = 0;
                    m_armed = 1'b0;
                end
            end else begin
                m_armed = 1'b1;
                if (h < 1024 && hue >= low && hue <= high) begin
                    mx += h; my += v; mc++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) px(1050, 800, 8'hFE);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (data_ready === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                check_eq("unexpected_pulse", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("x_com", x_com, e.x);
                check_eq("y_com", y_com, e.y);
                check_eq("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        low = 8'h00; high = 8'hFF;
        hcount = '0; vcount = '0; hsv = '0;

        // Reset held with arbitrary inputs
        for (int i = 0; i < 5; i++) begin
            px($urandom_range(0, 1100), $urandom_range(0, 900), 8'($urandom));
            check_eq("rst_x_com", x_com, 0);
            check_eq("rst_y_com", y_com, 0);
            check_eq("rst_data_ready", data_ready, 0);
        end
        mx = 0; my = 0; mc = 0; m_armed = 1'b1;
        rst_n = 1'b1;

        // Basic centroid
        low = 8'h0F; high = 8'hFF;
        px(1100, 0, 8'hFE);
        px(0, 0, 8'hFE);
        px(1, 0, 8'hFE);
        px(2, 0, 8'hFE);
        px(10, 0, 8'hFE);
        px(600, 500, 8'hFE);
        px(200, 500, 8'hFE);
        blank(40);
        check_eq("basic_x", x_com, 135);
        check_eq("basic_y", y_com, 166);

        // Hue window boundaries
        low = 8'h40; high = 8'h80;
        px(100, 10, 8'h40);
        px(300, 30, 8'h80);
        px(900, 700, 8'h3F);
        px(5, 5, 8'h81);
        blank(40);
        check_eq("window_x", x_com, 200);
        check_eq("window_y", y_com, 20);

        // Empty window: no pulse, outputs held
        low = 8'h90; high = 8'h10;
        px(100, 100, 8'h50);
        px(200, 200, 8'h95);
        px(300, 300, 8'h05);
        blank(40);
        check_eq("empty_x", x_com, 200);
        check_eq("empty_y", y_com, 20);

        // Single trigger despite jumping blanking vcount
        low = 8'h00; high = 8'hFF;
        px(50, 60, 8'h20);
        for (int i = 0; i < 200; i++)
            px($urandom_range(0, 1100), $urandom_range(768, 805), 8'($urandom));
        check_eq("single_x", x_com, 50);
        check_eq("single_y", y_com, 60);
        check_eq("single_pulses", pulses, 3);
        px(1023, 767, 8'h20);
        blank(40);
        check_eq("corner_x", x_com, 1023);
        check_eq("corner_y", y_com, 767);

        // Reset during division
        px(400, 300, 8'h20);
        px(600, 100, 8'h20);
        blank(10);
        rst_n = 1'b0;
        sb.delete();
        mx = 0; my = 0; mc = 0; m_armed = 1'b1;
        blank(2);
        check_eq("abort_x", x_com, 0);
        check_eq("abort_y", y_com, 0);
        check_eq("abort_ready", data_ready, 0);
        rst_n = 1'b1;
        blank(40);
        check_eq("abort_hold_x", x_com, 0);
        px(10, 20, 8'h20);
        px(30, 40, 8'h20);
        px(50, 60, 8'h20);
        blank(40);
        check_eq("after_abort_x", x_com, 30);
        check_eq("after_abort_y", y_com, 40);

        check_eq("scoreboard_drained", sb.size(), 0);
        check_eq("total_pulses", pulses, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
